// File: rtl/fft_output_reader.sv
// Purpose : drain the FFT result RAM in bit-reversed address order so samples leave in natural frequency order.
// Latency : 3 cycles from start to first out_valid; 1 sample/cycle steady state; done 1 cycle after the last pop.
// Backpressure: out_ready low holds out_data/out_valid; reads stall once FIFO occupancy + in-flight reaches 2.
//
// Ports:
//   clk, aclr (async, active-high), sclr (sync)   - clock and resets
//   start                                          - pulse: result buffer complete (accepted only in IDLE)
//   rd_en, rd_addr, rd_data                        - result-RAM read port (1-cycle read latency)
//   out_data, out_valid, out_ready, out_last       - output valid/ready stream, out_last on index N-1
//   busy, done                                     - frame in progress / one-cycle completion pulse
module fft_output_reader #(
    parameter int LOG2N  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              sclr,
    input  logic              start,
    output logic              rd_en,
    output logic [LOG2N-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [LOG2N:0]     r_idx;       // issue counter, 0..N
    logic [LOG2N-1:0]   r_ocnt;      // natural index of the FIFO head sample
    logic               r_inflight;  // a RAM read returns data this cycle
    logic [1:0]         r_occ;       // output FIFO occupancy, 0..2
    logic [DATA_W-1:0]  r_head;
    logic [DATA_W-1:0]  r_tail;
    logic               r_done;

    logic               w_run;
    logic               w_pop;
    logic               w_push;
    logic [2:0]         w_credit;
    logic [LOG2N-1:0]   w_rev;

    assign w_run  = (r_state == S_RUN);
    assign w_pop  = out_valid && out_ready;
    assign w_push = r_inflight;

    // Slots that will be claimed after this cycle: stored + returning - leaving.
    // Issuing only while this is below 2 keeps the 2-entry FIFO from overflowing.
    assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            w_rev[i] = r_idx[LOG2N-1-i];
        end
    end

    // r_idx never exceeds N, so its MSB alone marks "all reads issued".
    assign rd_en     = w_run && !r_idx[LOG2N] && (w_credit < 3'd2);
    assign rd_addr   = w_rev;
    assign out_data  = r_head;
    assign out_valid = (r_occ != 2'd0);
    assign out_last  = out_valid && (r_ocnt == {LOG2N{1'b1}});
    assign busy      = w_run;
    assign done      = r_done;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_ocnt     <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_done     <= 1'b0;
        end else if (sclr) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_ocnt     <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= rd_en;

            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse belongs to the old frame.
                    if (start && !r_done) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rd_en) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    if (w_pop) begin
                        r_ocnt <= r_ocnt + 1'b1;
                    end
                    if (w_pop && out_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_ocnt  <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Two-entry FIFO: head drives the output, tail backs it up.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= rd_data;
                    end else begin
                        r_tail <= rd_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= rd_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fft_output_reader.md
# fft_output_reader

Drains the FFT result buffer once a transform completes, issuing buffer reads in bit-reversed address order so that samples leave the block in natural frequency order. It sits between the radix-2 FFT core's result RAM (synchronous, one-cycle read latency) and the downstream consumer, with a valid/ready stream on the output. It is the read-side counterpart of the stage and sample counters that fill the buffer: those count up in natural order, and this block counts up and bit-reverses.

## Interface
Parameters:
- LOG2N, 3, log2 of transform length; N = 2^LOG2N samples per frame
- DATA_W, 32, width of one packed complex sample (real in upper half, imag in lower half)

Ports:
- clk  input  1  single clock; all logic on the rising edge
- aclr  input  1  asynchronous, active-high reset
- sclr  input  1  synchronous clear; same effect as aclr, applied on the clock edge
- start  input  1  one-cycle pulse from the FFT core: the result buffer is complete
- rd_en  output  1  result-RAM read enable
- rd_addr  output  LOG2N  result-RAM read address, bit-reversed
- rd_data  input  DATA_W  RAM read data, valid the cycle after rd_en
- out_data  output  DATA_W  output sample
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the sample when out_valid && out_ready
- out_last  output  1  high together with out_valid on natural index N-1
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last sample is accepted

## Operation
- FSM states: IDLE and RUN.
- IDLE -> RUN: start is sampled high. In IDLE, busy=0.
- RUN -> IDLE: the output handshake on the sample with out_last=1. done=1 for exactly one cycle after that.
- start is ignored while in RUN.
- Issue counter idx (LOG2N+1 bits) runs 0..N. The read address is rd_addr = bit-reverse of idx[LOG2N-1:0]. For N=8 the sequence is 0,4,2,6,1,5,3,7.
- Issue stops when idx=N.
- In-flight flag: set by rd_en, cleared the next cycle when rd_data is written into the output FIFO.
- Output FIFO: 2 entries; out_data and out_valid come from the head entry. There is no combinational path from rd_data to out_data.
- Credit rule: rd_en = RUN && idx<N && (occupancy + inflight - pop) < 2, where pop = out_valid && out_ready. This guarantees the FIFO never overflows.
- Output counter (0..N-1) increments on each pop. out_last = out_valid && (output counter == N-1).
- Reset values (aclr or sclr): state=IDLE; idx, output counter, inflight and occupancy all 0; rd_en=0, rd_addr=0, out_valid=0, out_last=0, busy=0, done=0, out_data=0.
- Reset mid-frame abandons the frame. Data returning from an outstanding read is discarded, and no done pulse is produced.
- A start pulse in the same cycle as the final pop, or as the done pulse, is ignored. A new frame needs start in IDLE.

## Timing
- start high in cycle 0 gives: busy=1 and rd_en=1 (rd_addr=0) in cycle 1; rd_data captured at the end of cycle 2; out_valid=1 in cycle 3.
- With out_ready held at 1: rd_en is high in cycles 1-8, out_valid is high in cycles 3-10, and out_last is high in cycle 10. In cycle 11, done=1 and busy=0. Steady throughput is 1 sample/cycle.
- If out_ready is low, out_data and out_valid stay stable. rd_en deasserts after at most 2 further reads, and resumes the cycle the credit rule allows.
- Latency from start to first sample: 3 cycles. Latency from the last pop to done: 1 cycle.

## Test plan
- RAM preloaded with addr*0x11, out_ready=1, start pulse: out_data sequence is 0x00,0x44,0x22,0x66,0x11,0x55,0x33,0x77 in cycles 3-10; out_last only on 0x77; done in cycle 11.
- out_ready low from cycle 3 to cycle 12: rd_en stops after 2 reads, out_data holds 0x00, and the FIFO never exceeds 2 entries. The full sequence then completes with no loss or duplication.
- out_ready toggling 1,0,1,0: 8 samples in order, each accepted exactly once; done follows one cycle after the last accept.
- start pulsed again in cycle 5 of a frame: ignored; exactly 8 outputs and one done pulse.
- aclr asserted in cycle 6: all outputs are 0 immediately, and the stale rd_data is not emitted. A following start yields a clean full frame from index 0.
- sclr asserted in cycle 4: the next edge gives IDLE with all outputs at reset values and no done pulse.
